// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and sizing helpers for the systolic scheduler
//
// Contents:
//   sched_state_t - scheduler phase (IDLE, LOAD, COMPUTE)
//   wave_count    - wavefront steps needed to fill and drain a ROWS x COLS array
//   cnt_width     - counter width for a modulus n, never narrower than one bit
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2
  } sched_state_t;

  function automatic int wave_count(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_wave_counter.sv
// rtl/sched_wave_counter.sv - stage/wave counter pair with wavefront enable decode
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - force both counters to zero at the next edge (wins over step)
//   step        - advance one stage cycle; counters hold when low
//   last        - current position is the final stage of the final wave
//   mask_next   - per-row multiply enables for the position the counters take next
module sched_wave_counter
  import systolic_pkg::*;
#(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int STAGE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            step,
  output logic            last,
  output logic [ROWS-1:0] mask_next
);

  localparam int W  = wave_count(ROWS, COLS);
  localparam int SW = cnt_width(STAGE_CYCLES);
  localparam int WW = cnt_width(W);

  logic [SW-1:0] stage_q, stage_d;
  logic [WW-1:0] wave_q, wave_d;
  logic          stage_end, wave_end;

  assign stage_end = (stage_q == SW'(STAGE_CYCLES - 1));
  assign wave_end  = (wave_q == WW'(W - 1));
  assign last      = stage_end && wave_end;

  // Wrapping after the last wave leaves the pair at zero, ready for the next tile.
  always_comb begin
    stage_d = stage_q;
    wave_d  = wave_q;
    if (clear) begin
      stage_d = '0;
      wave_d  = '0;
    end else if (step) begin
      if (stage_end) begin
        stage_d = '0;
        wave_d  = wave_end ? '0 : wave_q + 1'b1;
      end else begin
        stage_d = stage_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      wave_q  <= '0;
    end else begin
      stage_q <= stage_d;
      wave_q  <= wave_d;
    end
  end

  // Decoded from the next wave index so the parent can register the enables.
  // Row ROWS-1-i is active for waves i .. i+COLS-1 (MSB row leads the diagonal).
  always_comb begin
    mask_next = '0;
    for (int i = 0; i < ROWS; i++) begin
      mask_next[ROWS-1-i] = (int'(wave_d) >= i) && (int'(wave_d) <= i + COLS - 1);
    end
  end

endmodule

// File: rtl/systolic_scheduler.sv
// rtl/systolic_scheduler.sv - tile sequencer driving weight-load and multiply-enable rows
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   start        - begin a job (sampled in IDLE only), num_tiles captured with it
//   num_tiles    - number of tiles in the job
//   stall        - freeze sequencing; row strobes forced low while frozen
//   abort        - cancel the job and return to IDLE without pulses
//   busy         - job in progress (LOAD or COMPUTE)
//   load_weight  - one-hot row weight-load strobe
//   enable_mult  - per-row multiply enables (diagonal wavefront)
//   tile_idx     - current tile index, 0-based
//   tile_done    - one-cycle pulse per finished tile
//   done         - one-cycle pulse at job completion
module systolic_scheduler
  import systolic_pkg::*;
#(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int STAGE_CYCLES = 4,
  parameter int TILE_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              stall,
  input  logic              abort,
  output logic              busy,
  output logic [ROWS-1:0]   load_weight,
  output logic [ROWS-1:0]   enable_mult,
  output logic [TILE_W-1:0] tile_idx,
  output logic              tile_done,
  output logic              done
);

  localparam int RW = cnt_width(ROWS);

  sched_state_t      state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [TILE_W-1:0] tile_d, ntiles_q, ntiles_d;
  logic              hold, wave_last, tile_end, more_tiles;
  logic [ROWS-1:0]   mask_next, lw_d, en_d;
  logic              busy_d, td_d, done_d;

  // Stall only freezes an active job; in IDLE it must not swallow the first strobe.
  assign hold     = stall && (state_q != IDLE);
  assign tile_end = (state_q == COMPUTE) && !stall && wave_last;
  // One extra bit so num_tiles = 2^TILE_W-1 terminates instead of wrapping.
  assign more_tiles = ({1'b0, tile_idx} + (TILE_W+1)'(1)) < {1'b0, ntiles_q};

  sched_wave_counter #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .STAGE_CYCLES (STAGE_CYCLES)
  ) u_wave (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort || (state_q != COMPUTE)),
    .step      ((state_q == COMPUTE) && !stall),
    .last      (wave_last),
    .mask_next (mask_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      ntiles_q    <= '0;
      tile_idx    <= '0;
      busy        <= 1'b0;
      load_weight <= '0;
      enable_mult <= '0;
      tile_done   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      ntiles_q    <= ntiles_d;
      tile_idx    <= tile_d;
      busy        <= busy_d;
      load_weight <= lw_d;
      enable_mult <= en_d;
      tile_done   <= td_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    tile_d   = tile_idx;
    ntiles_d = ntiles_q;
    if (abort) begin
      state_d = IDLE;
      row_d   = '0;
      tile_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (num_tiles != '0)) begin
            state_d  = LOAD;
            row_d    = '0;
            tile_d   = '0;
            ntiles_d = num_tiles;
          end
        end
        LOAD: begin
          if (!stall) begin
            if (row_q == RW'(ROWS - 1)) begin
              state_d = COMPUTE;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (tile_end) begin
            if (more_tiles) begin
              state_d = LOAD;
              tile_d  = tile_idx + 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are the registered image of the position entered at this edge.
  always_comb begin
    busy_d = (state_d != IDLE);
    lw_d   = '0;
    en_d   = '0;
    if ((state_d == LOAD) && !hold) begin
      lw_d = ROWS'(1) << row_d;
    end
    if ((state_d == COMPUTE) && !hold) begin
      en_d = mask_next;
    end
    td_d   = !abort && tile_end;
    done_d = !abort && (((state_q == IDLE) && start && (num_tiles == '0)) ||
                        (tile_end && !more_tiles));
  end

endmodule

// File: doc/systolic_scheduler.md
# systolic_scheduler

Parametrised control sequencer for the weight-stationary systolic array. On a `start` handshake it runs a programmable number of tiles. Each tile has two phases: a row-by-row weight load, then a diagonal wavefront of per-row multiply enables that fills and drains the array. It supports a configurable stage length, stall, abort, and per-tile/completion pulses. It sits between the host command interface and the PE row control lines.

## Interface
- `ROWS`, default 2: PE rows (≥1).
- `COLS`, default 2: PE columns (≥1).
- `STAGE_CYCLES`, default 4: cycles per wavefront step (≥1).
- `TILE_W`, default 8: width of the tile count and index.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  begins a job when sampled high in IDLE; ignored otherwise.
- `num_tiles`  in  TILE_W  tile count, captured with `start`.
- `stall`  in  1  freezes sequencing while high.
- `abort`  in  1  synchronous cancel; return to IDLE.
- `busy`  out  1  high in LOAD and COMPUTE.
- `load_weight`  out  ROWS  one-hot row weight-load strobe.
- `enable_mult`  out  ROWS  per-row multiply enable.
- `tile_idx`  out  TILE_W  index of the current tile, 0-based.
- `tile_done`  out  1  one-cycle pulse per finished tile.
- `done`  out  1  one-cycle pulse when the job completes.

## Operation
- States are IDLE, LOAD and COMPUTE.
- All outputs are registered. The value in cycle n+1 reflects inputs and state sampled at edge n.
- Reset value is 0 for every output; the state is IDLE.
- **IDLE:**
  - `start`=1 with `num_tiles`≠0: go to LOAD, `tile_idx`=0.
  - `start`=1 with `num_tiles`=0: pulse `done` next cycle and stay in IDLE.
- **LOAD:** runs for `ROWS` cycles. In load cycle r (0..ROWS-1), `load_weight` = 1<<r. After the last load cycle, go to COMPUTE.
- **COMPUTE:** runs for W = ROWS+COLS-1 waves of `STAGE_CYCLES` cycles each.
  - In wave w, for i in 0..ROWS-1: `enable_mult[ROWS-1-i]` = 1 iff i ≤ w ≤ i+COLS-1. The MSB row starts first.
- **End of tile:** on the cycle after the last COMPUTE cycle, `tile_done` is 1.
  - If `tile_idx`+1 < `num_tiles`: `tile_idx` increments and LOAD restarts, so the first load strobe is in this same cycle.
  - Otherwise: `done`=1, `busy`=0, state is IDLE, and `tile_idx` holds its last value.
- **`stall`=1 at an edge (LOAD or COMPUTE):**
  - All counters and state hold.
  - Next-cycle `load_weight` and `enable_mult` are 0; `busy` stays 1.
  - Sequencing resumes exactly where it stopped.
- **`stall` and pulses:** a stall sampled on the tile-end edge delays `tile_done`/`done` until the stall drops. Pulses are never repeated.
- **`abort`=1 at any edge:** next cycle is IDLE with all outputs 0; no `tile_done` and no `done`. `abort` has priority over `stall` and `start`.
- **Arithmetic:**
  - Stage counter width is max(1,$clog2(STAGE_CYCLES)).
  - Wave counter width is max(1,$clog2(W)).
  - The tile counter is TILE_W bits and compares against the captured `num_tiles`, so there is no wrap for `num_tiles`=2^TILE_W-1.

## Timing
- Unstalled tile length: T = ROWS + W·STAGE_CYCLES.
- With `start` sampled at edge 0 (cycle 0):
  - Tile k (0-based) occupies cycles k·T+1 .. (k+1)·T.
  - `tile_done` fires in cycle (k+1)·T+1.
  - `done` fires in cycle N·T+1.
- Each stalled edge adds exactly one cycle.
- `start` may be re-asserted in the `done` cycle; it is accepted.

## Structure
- Shared package `systolic_pkg` holds:
  - the state enum `sched_state_t` (IDLE, LOAD, COMPUTE);
  - a function `wave_count(ROWS,COLS)`.
- One sub-module, `sched_wave_counter`, contains:
  - the stage/wave counter pair, with a hold-on-stall input;
  - a `last` flag output;
  - the combinational enable-mask decode from the wave index.

## Test plan
- ROWS=2, COLS=2, STAGE=4, N=1, start in cycle 0:
  - `load_weight`=01 in cycle 1 and 10 in cycle 2.
  - `enable_mult`=10 in cycles 3–6, 11 in cycles 7–10, 01 in cycles 11–14.
  - `tile_done`=`done`=1 in cycle 15.
- ROWS=4, COLS=3, STAGE=1, N=3:
  - `tile_done` in cycles 11, 21, 31; `done` in cycle 31.
  - `tile_idx` steps 0→1→2 in cycles 11 and 21.
- `num_tiles`=0: `done` in cycle 1, `busy` never asserts.
- `stall` high for cycles 5–7 of the first test: outputs are 0 in cycles 6–8, and `done` moves to cycle 18.
- `abort` in cycle 8 of the first test: all outputs 0 from cycle 9, no `done`. A new `start` in cycle 10 gives a normal run.
- Async `reset` pulse mid-COMPUTE:
  - Outputs clear immediately, without waiting for a clock edge.
  - `start` while busy is ignored, and `num_tiles` changes during a run have no effect.
